// File: rtl/sha256_core_arbiter_if.sv
// Requester-side and core-side signals of the shared SHA-256 core arbiter.
// master = requesters plus core (testbench side), slave = the arbiter.
interface sha256_core_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]     req_valid;
   logic [512*N_REQ-1:0] req_block;
   logic [N_REQ-1:0]     req_first;
   logic [N_REQ-1:0]     req_last;
   logic [N_REQ-1:0]     req_ready;
   logic [N_REQ-1:0]     resp_valid;
   logic [255:0]         resp_digest;
   logic                 core_init;
   logic [511:0]         core_block;
   logic                 core_first_block;
   logic [255:0]         core_prev_digest;
   logic                 core_digest_valid;
   logic [255:0]         core_digest;

   modport master (
      output req_valid, req_block, req_first, req_last, core_digest_valid, core_digest,
      input  req_ready, resp_valid, resp_digest, core_init, core_block, core_first_block,
             core_prev_digest
   );

   modport slave (
      input  req_valid, req_block, req_first, req_last, core_digest_valid, core_digest,
      output req_ready, resp_valid, resp_digest, core_init, core_block, core_first_block,
             core_prev_digest
   );
endinterface

// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core among N_REQ requesters; a requester
// keeps the core locked from its first block until its last block is digested.
module sha256_core_arbiter #(
   parameter int N_REQ = 4
) (
   input logic                 clk,
   input logic                 reset,
   sha256_core_arbiter_if.slave bus
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, LOCKED} state_t;

   state_t           state_reg;
   logic [IDX_W-1:0] last_grant_reg;
   logic [IDX_W-1:0] owner_reg;
   logic             last_flag_reg;
   logic [255:0]     chain_reg;
   logic [255:0]     resp_digest_reg;
   logic [511:0]     core_block_reg;
   logic             core_first_reg;
   logic             core_init_reg;
   logic [N_REQ-1:0] resp_valid_reg;

   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] cand;
   logic             any_req;
   logic             grant_en;
   logic [IDX_W-1:0] grant_idx;
   logic [N_REQ-1:0] ready;
   logic [511:0]     blk [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_blk
      assign blk[gi] = bus.req_block[512*gi +: 512];
   end

   // Scan downwards so the nearest requester after last_grant wins.
   always_comb begin
      winner  = last_grant_reg;
      any_req = 1'b0;
      cand    = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(last_grant_reg) + k) % N_REQ);
         if (bus.req_valid[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

   // Accept strobe is combinational so the block transfers in the requesting cycle;
   // it is masked by reset so no transfer is signalled while reset is held.
   always_comb begin
      ready     = '0;
      grant_en  = 1'b0;
      grant_idx = winner;
      if (!reset) begin
         if (state_reg == IDLE && any_req) begin
            grant_en  = 1'b1;
            grant_idx = winner;
         end else if (state_reg == LOCKED && bus.req_valid[owner_reg]) begin
            grant_en  = 1'b1;
            grant_idx = owner_reg;
         end
      end
      if (grant_en) begin
         ready[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         last_grant_reg  <= IDX_W'(N_REQ - 1);
         owner_reg       <= '0;
         last_flag_reg   <= 1'b0;
         chain_reg       <= '0;
         resp_digest_reg <= '0;
         core_block_reg  <= '0;
         core_first_reg  <= 1'b0;
         core_init_reg   <= 1'b0;
         resp_valid_reg  <= '0;
      end else begin
         core_init_reg  <= 1'b0;
         resp_valid_reg <= '0;
         case (state_reg)
            IDLE, LOCKED: begin
               if (grant_en) begin
                  core_block_reg <= blk[grant_idx];
                  core_first_reg <= bus.req_first[grant_idx];
                  last_flag_reg  <= bus.req_last[grant_idx];
                  owner_reg      <= grant_idx;
                  // The core substitutes its own IV for a first block.
                  if (bus.req_first[grant_idx]) begin
                     chain_reg <= '0;
                  end
                  core_init_reg  <= 1'b1;
                  state_reg      <= ISSUE;
               end
            end
            ISSUE: begin
               state_reg <= WAIT;
            end
            WAIT: begin
               if (bus.core_digest_valid) begin
                  chain_reg                 <= bus.core_digest;
                  resp_digest_reg           <= bus.core_digest;
                  resp_valid_reg[owner_reg] <= 1'b1;
                  state_reg                 <= DONE;
               end
            end
            DONE: begin
               if (last_flag_reg) begin
                  last_grant_reg <= owner_reg;
                  state_reg      <= IDLE;
               end else begin
                  state_reg <= LOCKED;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready        = ready;
   assign bus.resp_valid       = resp_valid_reg;
   assign bus.resp_digest      = resp_digest_reg;
   assign bus.core_init        = core_init_reg;
   assign bus.core_block       = core_block_reg;
   assign bus.core_first_block = core_first_reg;
   assign bus.core_prev_digest = chain_reg;
endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Directed and randomized checks of sha256_core_arbiter; the bench plays the SHA-256 core
// with a real compression function and predicts grants/chaining with a message-level model.
module tb_sha256_core_arbiter;
   localparam int N = 4;
   localparam logic [255:0] IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sha256_core_arbiter_if #(.N_REQ(N)) bus ();
   sha256_core_arbiter #(.N_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   int vectors = 0;
   int miscompares = 0;

   logic [N-1:0] rv, rf, rl;
   logic [511:0] rb [N];

   // Message-level reference state.
   int           m_last_grant;
   int           m_owner;
   bit           m_locked;
   logic [255:0] m_chain;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
              + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
      {a, b, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   function automatic int model_winner(input logic [N-1:0] v);
      if (m_locked) return v[m_owner] ? m_owner : -1;
      for (int k = 1; k <= N; k++)
         if (v[(m_last_grant + k) % N]) return (m_last_grant + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_last_grant = N - 1;
      m_owner      = 0;
      m_locked     = 1'b0;
      m_chain      = '0;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) bus.req_block[512*i +: 512] = rb[i];
      bus.req_valid = rv;
      bus.req_first = rf;
      bus.req_last  = rl;
   endtask

   // One full block transaction: grant, issue, core completion, response.
   task automatic txn(input bit keep, output int w);
      int           n;
      int           lat;
      logic [N-1:0] oh;
      logic [255:0] prev_exp, d;
      w = model_winner(rv);
      if (w < 0) begin
         chk("model_has_winner", 0, 1);
         $fatal(1, "no requester eligible, stopping");
      end
      oh = '0;
      oh[w] = 1'b1;
      n = 0;
      #1;
      while (bus.req_ready == '0 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (bus.req_ready == '0) begin
         chk("grant_timeout", 0, 1);
         $fatal(1, "no grant within cycle budget, stopping");
      end
      chk("req_ready", bus.req_ready, oh);
      prev_exp = rf[w] ? '0 : m_chain;
      d = sha_compress(rf[w] ? IV : prev_exp, rb[w]);
      @(negedge clk);
      chk("core_init_hi", bus.core_init, 1);
      chk("core_block", bus.core_block, rb[w]);
      chk("core_first", bus.core_first_block, rf[w]);
      chk("core_prev", bus.core_prev_digest, prev_exp);
      chk("ready_in_issue", bus.req_ready, 0);
      if (!keep) begin
         rv[w] = 1'b0;
         apply();
      end
      @(negedge clk);
      chk("core_init_lo", bus.core_init, 0);
      lat = $urandom_range(0, 3);
      repeat (lat) @(negedge clk);
      chk("resp_early", bus.resp_valid, 0);
      bus.core_digest_valid = 1'b1;
      bus.core_digest       = d;
      @(negedge clk);
      chk("resp_valid", bus.resp_valid, oh);
      chk("resp_digest", bus.resp_digest, d);
      chk("ready_in_done", bus.req_ready, 0);
      bus.core_digest_valid = 1'b0;
      bus.core_digest       = rand512();
      m_chain = d;
      if (rl[w]) begin
         m_last_grant = w;
         m_locked     = 1'b0;
      end else begin
         m_owner  = w;
         m_locked = 1'b1;
      end
      @(negedge clk);
      chk("resp_pulse", bus.resp_valid, 0);
      chk("resp_hold", bus.resp_digest, d);
      $display("txn: requester %0d first=%0d last=%0d digest=%0h", w, rf[w], rl[w], d);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           w, n;
      int           rr_order [5];
      logic [255:0] d1, held;
      rr_order = '{0, 1, 2, 3, 0};

      // Reset with a pending request: nothing may be accepted or issued.
      reset = 1'b1;
      rv = '0; rf = '0; rl = '0;
      for (int i = 0; i < N; i++) rb[i] = '0;
      rb[0] = rand512(); rf[0] = 1'b1; rl[0] = 1'b1; rv[0] = 1'b1;
      apply();
      bus.core_digest_valid = 1'b0;
      bus.core_digest       = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_core_init", bus.core_init, 0);
      chk("rst_core_block", bus.core_block, 0);
      chk("rst_core_first", bus.core_first_block, 0);
      chk("rst_core_prev", bus.core_prev_digest, 0);
      chk("rst_resp_digest", bus.resp_digest, 0);
      rv = '0;
      apply();
      @(negedge clk);
      reset = 1'b0;

      // Single-block "abc" from requester 0.
      rb[0] = {32'h61626380, 448'h0, 32'h00000018};
      rf[0] = 1'b1; rl[0] = 1'b1; rv[0] = 1'b1;
      apply();
      txn(1'b0, w);
      chk("abc_owner", w, 0);
      chk("abc_digest", bus.resp_digest,
          256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

      // Lock: requester 1 opens a message while requester 2 waits.
      rb[1] = rand512(); rf[1] = 1'b1; rl[1] = 1'b0; rv[1] = 1'b1;
      rb[2] = rand512(); rf[2] = 1'b1; rl[2] = 1'b1; rv[2] = 1'b1;
      apply();
      txn(1'b0, w);
      chk("lock_first_owner", w, 1);
      d1 = m_chain;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk("lock_starve", bus.req_ready, 0);
      end
      chk("lock_chain", bus.core_prev_digest, d1);
      rb[1] = rand512(); rf[1] = 1'b0; rl[1] = 1'b1; rv[1] = 1'b1;
      apply();
      txn(1'b0, w);
      chk("lock_last_owner", w, 1);
      txn(1'b0, w);
      chk("lock_release_owner", w, 2);

      // Spurious completion in IDLE.
      held = bus.resp_digest;
      bus.core_digest_valid = 1'b1;
      bus.core_digest       = rand512();
      @(negedge clk);
      bus.core_digest_valid = 1'b0;
      @(negedge clk);
      chk("spur_resp_valid", bus.resp_valid, 0);
      chk("spur_resp_digest", bus.resp_digest, held);
      chk("spur_core_init", bus.core_init, 0);

      // Restart chaining inside a lock while requester 0 waits.
      rb[3] = rand512(); rf[3] = 1'b1; rl[3] = 1'b0; rv[3] = 1'b1;
      apply();
      txn(1'b0, w);
      chk("restart_owner", w, 3);
      rb[3] = rand512(); rf[3] = 1'b1; rl[3] = 1'b0; rv[3] = 1'b1;
      rb[0] = rand512(); rf[0] = 1'b1; rl[0] = 1'b1; rv[0] = 1'b1;
      apply();
      txn(1'b0, w);
      chk("restart_again_owner", w, 3);
      #1;
      chk("restart_lock_held", bus.req_ready, 0);
      rb[3] = rand512(); rf[3] = 1'b0; rl[3] = 1'b1; rv[3] = 1'b1;
      apply();
      txn(1'b0, w);
      chk("restart_last_owner", w, 3);
      txn(1'b0, w);
      chk("restart_waiter_owner", w, 0);

      // Reset while waiting on the core.
      rb[2] = rand512(); rf[2] = 1'b1; rl[2] = 1'b1; rv = 4'b0100;
      apply();
      #1;
      n = 0;
      while (bus.req_ready != 4'b0100 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("wait_rst_grant", bus.req_ready, 4'b0100);
      @(negedge clk);
      rv = '0;
      apply();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         rb[i] = rand512(); rf[i] = 1'b1; rl[i] = 1'b1;
      end
      rv = '1;
      apply();
      reset = 1'b1;
      #1;
      chk("wrst_req_ready", bus.req_ready, 0);
      chk("wrst_resp_valid", bus.resp_valid, 0);
      chk("wrst_core_init", bus.core_init, 0);
      chk("wrst_core_block", bus.core_block, 0);
      chk("wrst_core_first", bus.core_first_block, 0);
      chk("wrst_core_prev", bus.core_prev_digest, 0);
      chk("wrst_resp_digest", bus.resp_digest, 0);
      model_reset();
      rv = '0;
      apply();
      @(negedge clk);
      reset = 1'b0;
      bus.core_digest_valid = 1'b1;
      bus.core_digest       = rand512();
      @(negedge clk);
      bus.core_digest_valid = 1'b0;
      @(negedge clk);
      chk("late_resp_valid", bus.resp_valid, 0);
      chk("late_core_init", bus.core_init, 0);
      chk("late_resp_digest", bus.resp_digest, 0);

      // Round-robin from reset with all requesters held.
      rv = '1;
      apply();
      for (int k = 0; k < 5; k++) begin
         txn(1'b1, w);
         chk("rr_order", w, rr_order[k]);
      end
      rv = '0;
      apply();

      // Random multi-block messages with random contenders.
      for (int m = 0; m < 10; m++) begin
         int r, nb, sent;
         r  = $urandom_range(0, N - 1);
         nb = $urandom_range(1, 3);
         for (int i = 0; i < N; i++) begin
            if (i != r && $urandom_range(0, 2) == 0) begin
               rb[i] = rand512(); rf[i] = 1'b1; rl[i] = 1'b1; rv[i] = 1'b1;
            end
         end
         rb[r] = rand512(); rf[r] = 1'b1; rl[r] = (nb == 1); rv[r] = 1'b1;
         sent = 0;
         apply();
         while (rv != '0) begin
            txn(1'b0, w);
            if (w == r) begin
               sent++;
               if (sent < nb) begin
                  rb[r] = rand512(); rf[r] = ($urandom_range(0, 4) == 0);
                  rl[r] = (sent == nb - 1); rv[r] = 1'b1;
                  apply();
               end
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
